jk_pulse_conditioner: RTL and testbench

//  Upstream front-end for the moore_state JK FSM. It takes two raw, asynchronous, bouncy button

---
 rtl/jk_pulse_conditioner.sv | 122 ++++++++++++
 tb/tb_jk_pulse_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/jk_pulse_conditioner.sv
// Button front-end for the JK FSM: synchronize, debounce and edge-detect two raw lines,
// then arbitrate so j and k never strobe together. Define JK_AUTOREPEAT_EN for held-key repeat.
module jk_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic j_raw,
  input  logic k_raw,
  output logic j,
  output logic k,
  output logic conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is J, index 1 is K.
  logic [1:0]    raw;
  logic [1:0]    sync1, sync2;
  logic [1:0]    st, st_d;
  logic [CW-1:0] cnt [2];
  logic [1:0]    rise;
  logic          pending_k;
  logic          j_nxt, k_nxt, conflict_nxt, pending_nxt, k_req;

  assign raw = {k_raw, j_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      st    <= '0;
      st_d  <= '0;
      // NOTE: the debounce counters are per-channel state, so every element is
      // cleared explicitly; a partial count must never survive a reset.
      for (int ch = 0; ch < 2; ch++) cnt[ch] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      st_d  <= st;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2[ch] != st[ch]) begin
          if (cnt[ch] == CNT_LAST) begin
            st[ch]  <= sync2[ch];
            cnt[ch] <= '0;
          end else begin
            cnt[ch] <= cnt[ch] + 1'b1;
          end
        end else begin
          cnt[ch] <= '0;
        end
      end
    end
  end

`ifdef JK_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_ev;

  // A repeat fires REPEAT_CYCLES clocks after the previous event of that channel.
  always_comb begin
    for (int ch = 0; ch < 2; ch++)
      rep_ev[ch] = st[ch] & st_d[ch] & (rep_cnt[ch] == REP_LAST);
  end

  assign rise = (st & ~st_d) | rep_ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) rep_cnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (!st[ch] || rise[ch])
          rep_cnt[ch] <= '0;
        else if (rep_cnt[ch] != REP_LAST)
          rep_cnt[ch] <= rep_cnt[ch] + 1'b1;
      end
    end
  end
`else
  assign rise = st & ~st_d;
`endif

  // J always wins; a competing k request (fresh or already deferred) waits one cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    j_nxt        = 1'b0;
    k_nxt        = 1'b0;
    conflict_nxt = 1'b0;
    pending_nxt  = 1'b0;
    k_req        = rise[1] | pending_k;
    if (rise[0]) begin
      j_nxt        = 1'b1;
      pending_nxt  = k_req;
      conflict_nxt = k_req;
    end else begin
      k_nxt = k_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      j         <= 1'b0;
      k         <= 1'b0;
      conflict  <= 1'b0;
      pending_k <= 1'b0;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      j         <= j_nxt;
      k         <= k_nxt;
      conflict  <= conflict_nxt;
      pending_k <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_jk_pulse_conditioner.sv
// Scoreboard bench for jk_pulse_conditioner: directed button patterns push expected
// strobes (cycle, j, k, conflict); a negedge monitor pops and compares each observed strobe.
module tb_jk_pulse_conditioner;

  logic clk = 1'b0;
  logic reset, j_raw, k_raw;
  logic j, k, conflict;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int e0;
  logic [63:0] exp_q [$];

  jk_pulse_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .j_raw(j_raw), .k_raw(k_raw),
    .j(j), .k(k), .conflict(conflict)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pack(input int c, input logic pj, input logic pk, input logic pc);
    return {32'(c), 29'b0, pj, pk, pc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_strobe(input int c, input logic pj, input logic pk, input logic pc);
    exp_q.push_back(pack(c, pj, pk, pc));
  endtask

  // Monitor: every cycle with any output high must match the head of the scoreboard.
  always @(negedge clk) begin
    if (j || k || conflict) begin
      check("exclusive_jk", 64'(j & k), 64'd0);
      if (exp_q.size() == 0)
        check("unexpected_strobe", pack(cyc, j, k, conflict), 64'd0);
      else
        check("strobe", pack(cyc, j, k, conflict), exp_q.pop_front());
    end
  end

  initial begin
    reset = 1'b1;
    j_raw = 1'b0;
    k_raw = 1'b0;
    tick(1);
    check("reset_j", 64'(j), 64'd0);
    check("reset_k", 64'(k), 64'd0);
    check("reset_conflict", 64'(conflict), 64'd0);
    tick(1);
    reset = 1'b0;
    tick(8);
    check("idle_outputs", 64'({j, k, conflict}), 64'd0);

    // Reset mid-debounce: four raw samples would be enough, reset discards them.
    j_raw = 1'b1;
    tick(4);
    reset = 1'b1;
    j_raw = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(15);

    // Held J press: one strobe after E6 (repeats only with auto-repeat).
    j_raw = 1'b1;
    e0 = cyc + 1;
    expect_strobe(e0 + 6, 1'b1, 1'b0, 1'b0);
`ifdef JK_AUTOREPEAT_EN
    expect_strobe(e0 + 22, 1'b1, 1'b0, 1'b0);
    expect_strobe(e0 + 38, 1'b1, 1'b0, 1'b0);
`endif
    tick(40);
    j_raw = 1'b0;
    tick(20);

    // K bounce 1,0,1,1,0 and a 3-cycle pulse: both rejected.
    k_raw = 1'b1; tick(1);
    k_raw = 1'b0; tick(1);
    k_raw = 1'b1; tick(2);
    k_raw = 1'b0; tick(10);
    k_raw = 1'b1; tick(3);
    k_raw = 1'b0; tick(12);

    // Simultaneous press: j with conflict after E6, deferred k after E7.
    j_raw = 1'b1;
    k_raw = 1'b1;
    e0 = cyc + 1;
    expect_strobe(e0 + 6, 1'b1, 1'b0, 1'b1);
    expect_strobe(e0 + 7, 1'b0, 1'b1, 1'b0);
    tick(10);
    j_raw = 1'b0;
    k_raw = 1'b0;
    tick(15);

    // K alone.
    k_raw = 1'b1;
    e0 = cyc + 1;
    expect_strobe(e0 + 6, 1'b0, 1'b1, 1'b0);
    tick(10);
    k_raw = 1'b0;
    tick(15);

    // K two clocks behind J: no conflict, no deferral.
    j_raw = 1'b1;
    e0 = cyc + 1;
    tick(2);
    k_raw = 1'b1;
    expect_strobe(e0 + 6, 1'b1, 1'b0, 1'b0);
    expect_strobe(e0 + 8, 1'b0, 1'b1, 1'b0);
    tick(10);
    j_raw = 1'b0;
    k_raw = 1'b0;
    tick(15);

    // Press / release / press, 10 clocks each: two strobes 20 apart, none on release.
    j_raw = 1'b1;
    e0 = cyc + 1;
    expect_strobe(e0 + 6, 1'b1, 1'b0, 1'b0);
    expect_strobe(e0 + 26, 1'b1, 1'b0, 1'b0);
    tick(10);
    j_raw = 1'b0;
    tick(10);
    j_raw = 1'b1;
    tick(10);
    j_raw = 1'b0;
    tick(20);

`ifdef JK_AUTOREPEAT_EN
    // Auto-repeat on K: strobes after E6, E22, E38, silent after release.
    k_raw = 1'b1;
    e0 = cyc + 1;
    expect_strobe(e0 + 6, 1'b0, 1'b1, 1'b0);
    expect_strobe(e0 + 22, 1'b0, 1'b1, 1'b0);
    expect_strobe(e0 + 38, 1'b0, 1'b1, 1'b0);
    tick(44);
    k_raw = 1'b0;
    tick(30);
`endif

    check("all_strobes_seen", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'({j, k, conflict}), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
